// File: rtl/deserializer.sv
// Serial-to-parallel deserializer: collects MSB-first frames delimited by a valid run.
// Optional short-frame flag enabled with `define DESERIALIZER_RUNT_FLAG_EN.
module deserializer #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned MIN_LEN = 3
) (
  input  logic                     clk_i,
  input  logic                     arstn_i,
  input  logic                     ser_data_i,
  input  logic                     ser_data_val_i,
  output logic [WIDTH-1:0]         deser_data_o,
  output logic [$clog2(WIDTH)-1:0] deser_data_mod_o,
  output logic                     deser_data_val_o,
  output logic                     busy_o,
  output logic                     runt_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [WIDTH-1:0] r_data,  w_data_nxt;
  logic [CNT_W-1:0] r_mod,   w_mod_nxt;
  logic             r_val,   w_val_nxt;
  logic             r_busy,  w_busy_nxt;
  logic [CNT_W-1:0] w_pos;
`ifdef DESERIALIZER_RUNT_FLAG_EN
  logic             r_runt,  w_runt_nxt;
`endif

  // Next-state, bit placement and frame-close decisions
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_mod_nxt   = r_mod;
    w_val_nxt   = 1'b0;
`ifdef DESERIALIZER_RUNT_FLAG_EN
    w_runt_nxt  = 1'b0;
`endif
    w_pos       = LAST_CNT - r_count;

    unique case (r_state)
      IDLE: begin
        if (ser_data_val_i) begin
          // Fresh frame: clear stale bits so unused LSBs read as zero
          w_shift_nxt            = '0;
          w_shift_nxt[WIDTH-1]   = ser_data_i;
          w_count_nxt            = CNT_W'(1);
          w_state_nxt            = COLLECT;
        end
      end
      COLLECT: begin
        if (ser_data_val_i) begin
          w_shift_nxt[w_pos] = ser_data_i;
          if (r_count == LAST_CNT) begin
            w_state_nxt = IDLE;
            w_count_nxt = '0;
            w_data_nxt  = w_shift_nxt;
            w_mod_nxt   = '0;
            w_val_nxt   = 1'b1;
          end else begin
            w_count_nxt = r_count + CNT_W'(1);
          end
        end else begin
          w_state_nxt = IDLE;
          w_count_nxt = '0;
          if (32'(r_count) >= MIN_LEN) begin
            w_data_nxt = r_shift;
            w_mod_nxt  = r_count;
            w_val_nxt  = 1'b1;
          end else begin
`ifdef DESERIALIZER_RUNT_FLAG_EN
            w_runt_nxt = 1'b1;
`endif
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_count_nxt = '0;
      end
    endcase

    w_busy_nxt = (w_state_nxt == COLLECT);
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state <= IDLE;
      r_count <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_mod   <= '0;
      r_val   <= 1'b0;
      r_busy  <= 1'b0;
`ifdef DESERIALIZER_RUNT_FLAG_EN
      r_runt  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_mod   <= w_mod_nxt;
      r_val   <= w_val_nxt;
      r_busy  <= w_busy_nxt;
`ifdef DESERIALIZER_RUNT_FLAG_EN
      r_runt  <= w_runt_nxt;
`endif
    end
  end

  assign deser_data_o     = r_data;
  assign deser_data_mod_o = r_mod;
  assign deser_data_val_o = r_val;
  assign busy_o           = r_busy;
`ifdef DESERIALIZER_RUNT_FLAG_EN
  assign runt_o           = r_runt;
`else
  assign runt_o           = 1'b0;
`endif

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer: directed frames plus random frames against a frame-level model.
module tb_deserializer;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned MIN_LEN = 3;
  localparam int unsigned MOD_W   = $clog2(WIDTH);

  logic             clk_i = 1'b0;
  logic             arstn_i;
  logic             ser_data_i;
  logic             ser_data_val_i;
  logic [WIDTH-1:0] deser_data_o;
  logic [MOD_W-1:0] deser_data_mod_o;
  logic             deser_data_val_o;
  logic             busy_o;
  logic             runt_o;

  deserializer #(.WIDTH(WIDTH), .MIN_LEN(MIN_LEN)) dut (
    .clk_i            (clk_i),
    .arstn_i          (arstn_i),
    .ser_data_i       (ser_data_i),
    .ser_data_val_i   (ser_data_val_i),
    .deser_data_o     (deser_data_o),
    .deser_data_mod_o (deser_data_mod_o),
    .deser_data_val_o (deser_data_val_o),
    .busy_o           (busy_o),
    .runt_o           (runt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  // Frame-level reference: bits of the open frame, plus expected registered outputs
  int               q_bits[$];
  int               pulse_cyc[$];
  logic [WIDTH-1:0] exp_data;
  int               exp_mod;
  logic             exp_val;
  logic             exp_busy;
  logic             exp_runt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q_bits.delete();
    exp_data = '0;
    exp_mod  = 0;
    exp_val  = 1'b0;
    exp_busy = 1'b0;
    exp_runt = 1'b0;
  endtask

  task automatic model_close();
    int len;
    logic [WIDTH-1:0] w;
    len = q_bits.size();
    if (len >= int'(MIN_LEN)) begin
      w = '0;
      foreach (q_bits[k]) w[WIDTH-1-k] = q_bits[k][0];
      exp_data = w;
      exp_mod  = len % int'(WIDTH);
      exp_val  = 1'b1;
    end else begin
`ifdef DESERIALIZER_RUNT_FLAG_EN
      exp_runt = 1'b1;
`endif
    end
    q_bits.delete();
  endtask

  task automatic model_step(input logic val, input logic b);
    exp_val  = 1'b0;
    exp_runt = 1'b0;
    if (val) begin
      q_bits.push_back(int'(b));
      if (q_bits.size() == int'(WIDTH)) model_close();
    end else if (q_bits.size() > 0) begin
      model_close();
    end
    exp_busy = (q_bits.size() > 0);
  endtask

  task automatic check_outputs();
    chk("val",  32'(deser_data_val_o), 32'(exp_val));
    chk("data", 32'(deser_data_o),     32'(exp_data));
    chk("mod",  32'(deser_data_mod_o), 32'(exp_mod));
    chk("busy", 32'(busy_o),           32'(exp_busy));
    chk("runt", 32'(runt_o),           32'(exp_runt));
  endtask

  // One clock: drive inputs away from the edge, sample 1ns after it
  task automatic step(input logic val, input logic b);
    ser_data_val_i = val;
    ser_data_i     = b;
    @(posedge clk_i);
    #1;
    cyc++;
    model_step(val, b);
    if (deser_data_val_o) pulse_cyc.push_back(cyc);
    check_outputs();
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    logic [31:0] tmp;
    tmp = v;
    for (int k = 0; k < n; k++) step(1'b1, tmp[n-1-k]);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'($urandom));
  endtask

  initial begin
    logic [15:0] ctr;
    logic [15:0] rev;
    int len;
    arstn_i        = 1'b0;
    ser_data_i     = 1'b0;
    ser_data_val_i = 1'b0;
    model_reset();
    #3;
    check_outputs();
    #19;
    arstn_i = 1'b1;

    // Full 16-bit frame
    send_bits(32'hA5C3, 16);
    chk("a5c3_data", 32'(deser_data_o), 32'h0000A5C3);
    chk("a5c3_val",  32'(deser_data_val_o), 32'd1);
    chk("a5c3_busy", 32'(busy_o), 32'd0);
    idle(2);

    // Minimum-length frame
    send_bits(32'b101, 3);
    idle(1);
    chk("len3_data", 32'(deser_data_o), 32'h0000A000);
    chk("len3_mod",  32'(deser_data_mod_o), 32'd3);
    idle(1);

    // Runt frame: dropped
    send_bits(32'b11, 2);
    idle(1);
    chk("runt_data", 32'(deser_data_o), 32'h0000A000);
    chk("runt_noval", 32'(deser_data_val_o), 32'd0);
    idle(1);

    // Back-to-back full frames
    pulse_cyc.delete();
    send_bits(32'hFFFF, 16);
    send_bits(32'h0001, 16);
    idle(1);
    chk("b2b_count", 32'(pulse_cyc.size()), 32'd2);
    if (pulse_cyc.size() == 2) chk("b2b_gap", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd16);
    chk("b2b_last", 32'(deser_data_o), 32'h00000001);

    // Reset in the middle of a frame
    send_bits(32'h55, 7);
    #1;
    arstn_i = 1'b0;
    #1;
    model_reset();
    check_outputs();
    #1;
    arstn_i = 1'b1;
    pulse_cyc.delete();
    idle(2);
    send_bits(32'h5A, 8);
    idle(1);
    chk("rst_pulses", 32'(pulse_cyc.size()), 32'd1);
    chk("rst_data", 32'(deser_data_o), 32'h00005A00);
    chk("rst_mod",  32'(deser_data_mod_o), 32'd8);
    idle(1);

    // Length sweep with bit-reversed counter values
    for (int l = 3; l <= 16; l++) begin
      ctr = 16'(l * 37 + 5);
      for (int i = 0; i < 16; i++) rev[i] = ctr[15-i];
      send_bits(32'(rev >> (16 - l)), l);
      idle(1);
    end

    // Random frames, gaps and over-length runs
    for (int f = 0; f < 40; f++) begin
      len = int'($urandom_range(0, 20));
      send_bits($urandom, len);
      idle(int'($urandom_range(0, 2)));
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
